// File: rtl/ahb_pkg.sv
// Shared AHB encodings, plus the response-mux select and default-slave state codes.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        SEL_DEF = 2'd0,
        SEL_S1  = 2'd1,
        SEL_S2  = 2'd2
    } sel_e;

    localparam logic [1:0] DS_IDLE = 2'd0;
    localparam logic [1:0] DS_ERR1 = 2'd1;
    localparam logic [1:0] DS_ERR2 = 2'd2;

    // NONSEQ and SEQ carry data; IDLE and BUSY get a zero-wait OKAY.
    function automatic logic is_transfer(input logic [1:0] htrans);
        case (htrans)
            HTRANS_IDLE, HTRANS_BUSY:  return 1'b0;
            HTRANS_NONSEQ, HTRANS_SEQ: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped addresses: two-cycle ERROR for real transfers, OKAY otherwise.
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       HSEL,
    input  logic [1:0] HTRANS,
    input  logic       HREADY,
    output logic       HREADYOUT,
    output logic       HRESP
);

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       req;

    assign req = HSEL && is_transfer(HTRANS);

    always_comb begin
        // NOTE: assign a default before the case so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            DS_IDLE: if (HREADY && req) state_d = DS_ERR1;
            DS_ERR1: state_d = DS_ERR2;
            DS_ERR2: state_d = req ? DS_ERR1 : DS_IDLE;
            default: state_d = DS_IDLE;
        endcase
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= DS_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = RESP_OKAY;
        case (state_q)
            DS_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = RESP_ERROR;
            end
            DS_ERR2: HRESP = RESP_ERROR;
            default: ;
        endcase
    end

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB slave-to-master response mux with a data-phase select register and a default slave.
module ahb_resp_mux
    import ahb_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL_Default,
    input  logic        HSEL_S1,
    input  logic        HSEL_S2,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HRDATA_S1,
    input  logic [31:0] HRDATA_S2,
    input  logic        HREADYOUT_S1,
    input  logic        HREADYOUT_S2,
    input  logic        HRESP_S1,
    input  logic        HRESP_S2,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP
);

    sel_e sel_q;
    logic def_readyout;
    logic def_resp;

    ahb_default_slave u_default_slave (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL_Default),
        .HTRANS    (HTRANS),
        .HREADY    (HREADY),
        .HREADYOUT (def_readyout),
        .HRESP     (def_resp)
    );

    // Address phase is accepted only when the current data phase completes.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_q <= SEL_DEF;
        end else if (HREADY) begin
            if (HSEL_S1)      sel_q <= SEL_S1;
            else if (HSEL_S2) sel_q <= SEL_S2;
            else              sel_q <= SEL_DEF;
        end
    end

    always_comb begin
        HRDATA = 32'h0000_0000;
        HREADY = def_readyout;
        HRESP  = def_resp;
        case (sel_q)
            SEL_S1: begin
                HRDATA = HRDATA_S1;
                HREADY = HREADYOUT_S1;
                HRESP  = HRESP_S1;
            end
            SEL_S2: begin
                HRDATA = HRDATA_S2;
                HREADY = HREADYOUT_S2;
                HRESP  = HRESP_S2;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Scoreboarded bench for ahb_resp_mux: directed bus scenarios followed by random traffic.
module tb_ahb_resp_mux;

    typedef struct packed {
        logic [31:0] rdata;
        logic        ready;
        logic        resp;
    } exp_t;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL_Default = 1'b0;
    logic        HSEL_S1 = 1'b0;
    logic        HSEL_S2 = 1'b0;
    logic [1:0]  HTRANS = 2'b00;
    logic [31:0] HRDATA_S1 = '0;
    logic [31:0] HRDATA_S2 = '0;
    logic        HREADYOUT_S1 = 1'b1;
    logic        HREADYOUT_S2 = 1'b1;
    logic        HRESP_S1 = 1'b0;
    logic        HRESP_S2 = 1'b0;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    int n_checks = 0;
    int n_fail = 0;

    exp_t exp_q[$];
    exp_t cur_exp = '{rdata: 32'h0, ready: 1'b1, resp: 1'b0};

    // Reference model: which slave owns the data phase, and the queued default-slave responses.
    int         m_owner = 0;   // 0 default, 1 S1, 2 S2
    logic [1:0] m_dq[$];       // {ready, resp} per upcoming cycle

    ahb_resp_mux dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .HSEL_Default (HSEL_Default),
        .HSEL_S1      (HSEL_S1),
        .HSEL_S2      (HSEL_S2),
        .HTRANS       (HTRANS),
        .HRDATA_S1    (HRDATA_S1),
        .HRDATA_S2    (HRDATA_S2),
        .HREADYOUT_S1 (HREADYOUT_S1),
        .HREADYOUT_S2 (HREADYOUT_S2),
        .HRESP_S1     (HRESP_S1),
        .HRESP_S2     (HRESP_S2),
        .HRDATA       (HRDATA),
        .HREADY       (HREADY),
        .HRESP        (HRESP)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got rdata=%h ready=%b resp=%b, expected rdata=%h ready=%b resp=%b (t=%0t)",
                     name, act[33:2], act[1], act[0], exp[33:2], exp[1], exp[0], $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e = '{rdata: 32'h0, ready: 1'b1, resp: 1'b0};
        if (!HRESETn) begin
            m_owner = 0;
            m_dq.delete();
        end else if (m_owner == 1) begin
            e = '{rdata: HRDATA_S1, ready: HREADYOUT_S1, resp: HRESP_S1};
        end else if (m_owner == 2) begin
            e = '{rdata: HRDATA_S2, ready: HREADYOUT_S2, resp: HRESP_S2};
        end else if (m_dq.size() != 0) begin
            e.ready = m_dq[0][1];
            e.resp  = m_dq[0][0];
        end
        return e;
    endfunction

    // Advance the model across one rising edge using the inputs held during the cycle.
    function automatic void model_clock();
        int  pending;
        logic accept_err;
        if (!HRESETn) begin
            m_owner = 0;
            m_dq.delete();
            return;
        end
        pending = m_dq.size();
        if (pending != 0) void'(m_dq.pop_front());
        // Idle default slave needs a completed data phase; its second error cycle does not.
        accept_err = (pending == 0) ? cur_exp.ready : (pending == 1);
        if (accept_err && HSEL_Default && HTRANS[1]) begin
            m_dq.push_back(2'b01);
            m_dq.push_back(2'b11);
        end
        if (cur_exp.ready) m_owner = HSEL_S1 ? 1 : (HSEL_S2 ? 2 : 0);
    endfunction

    task automatic drive(input logic rst, input logic hd, input logic h1, input logic h2,
                         input logic [1:0] tr, input logic [31:0] d1, input logic [31:0] d2,
                         input logic r1, input logic r2, input logic e1, input logic e2);
        @(posedge HCLK);
        model_clock();
        #1;
        HRESETn = rst;  HSEL_Default = hd;  HSEL_S1 = h1;  HSEL_S2 = h2;  HTRANS = tr;
        HRDATA_S1 = d1; HRDATA_S2 = d2;
        HREADYOUT_S1 = r1; HREADYOUT_S2 = r2; HRESP_S1 = e1; HRESP_S2 = e2;
        cur_exp = model_out();
        exp_q.push_back(cur_exp);
    endtask

    task automatic expect_now(input string name, input logic [31:0] rdata,
                              input logic ready, input logic resp);
        @(negedge HCLK);
        check(name, {HRDATA, HREADY, HRESP}, {rdata, ready, resp});
    endtask

    // Monitor: the DUT presents a response every cycle; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge HCLK);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("scoreboard", {HRDATA, HREADY, HRESP}, e);
            end
        end
    end

    initial begin
        int   rst_cnt;
        int   pick;
        logic hd, h1, h2;

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 0, 2'b10, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 1, 1, 1, 1);
            expect_now("reset_hold", 32'h0, 1'b1, 1'b0);
        end

        // S1 read.
        drive(1, 0, 1, 0, 2'b10, 32'h0, 32'h0, 1, 1, 0, 0);
        drive(1, 0, 0, 0, 2'b00, 32'hDEAD_BEEF, 32'h0, 1, 1, 0, 0);
        expect_now("s1_read", 32'hDEAD_BEEF, 1'b1, 1'b0);

        // S2 wait states while S1 is requested.
        drive(1, 0, 0, 1, 2'b10, 32'h0, 32'h0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 0, 2'b10, 32'h1111_1111, 32'h2222_2222, 1, 0, 0, 0);
            expect_now("s2_wait", 32'h2222_2222, 1'b0, 1'b0);
        end
        drive(1, 0, 1, 0, 2'b10, 32'h1111_1111, 32'h2222_2222, 1, 1, 0, 0);
        expect_now("s2_done", 32'h2222_2222, 1'b1, 1'b0);
        drive(1, 0, 0, 0, 2'b00, 32'h1111_1111, 32'h2222_2222, 1, 1, 0, 0);
        expect_now("switch_s1", 32'h1111_1111, 1'b1, 1'b0);

        // S2 error passes straight through.
        drive(1, 0, 0, 1, 2'b10, 32'h0, 32'h0, 1, 1, 0, 0);
        drive(1, 0, 0, 0, 2'b00, 32'h0, 32'h5555_0000, 1, 1, 0, 1);
        expect_now("s2_error", 32'h5555_0000, 1'b1, 1'b1);

        // Unmapped NONSEQ: two-cycle error then OKAY.
        drive(1, 1, 0, 0, 2'b10, 32'h0, 32'h0, 1, 1, 0, 0);
        drive(1, 0, 0, 0, 2'b00, 32'h0, 32'h0, 1, 1, 0, 0);
        expect_now("unmapped_err1", 32'h0, 1'b0, 1'b1);
        drive(1, 0, 0, 0, 2'b00, 32'h0, 32'h0, 1, 1, 0, 0);
        expect_now("unmapped_err2", 32'h0, 1'b1, 1'b1);
        drive(1, 0, 0, 0, 2'b00, 32'h0, 32'h0, 1, 1, 0, 0);
        expect_now("unmapped_okay", 32'h0, 1'b1, 1'b0);

        // Back-to-back errors: a new NONSEQ is presented during the second error cycle.
        drive(1, 1, 0, 0, 2'b10, 32'h0, 32'h0, 1, 1, 0, 0);
        drive(1, 1, 0, 0, 2'b10, 32'h0, 32'h0, 1, 1, 0, 0);
        expect_now("b2b_1", 32'h0, 1'b0, 1'b1);
        drive(1, 1, 0, 0, 2'b10, 32'h0, 32'h0, 1, 1, 0, 0);
        expect_now("b2b_2", 32'h0, 1'b1, 1'b1);
        drive(1, 0, 0, 0, 2'b00, 32'h0, 32'h0, 1, 1, 0, 0);
        expect_now("b2b_3", 32'h0, 1'b0, 1'b1);
        drive(1, 0, 0, 0, 2'b00, 32'h0, 32'h0, 1, 1, 0, 0);
        expect_now("b2b_4", 32'h0, 1'b1, 1'b1);

        // IDLE to default slave gets zero-wait OKAY.
        drive(1, 1, 0, 0, 2'b00, 32'h0, 32'h0, 1, 1, 0, 0);
        drive(1, 0, 0, 0, 2'b00, 32'h0, 32'h0, 1, 1, 0, 0);
        expect_now("default_idle", 32'h0, 1'b1, 1'b0);

        // Reset during the first error cycle, then a normal transfer right after release.
        drive(1, 1, 0, 0, 2'b10, 32'h0, 32'h0, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 1, 1, 0, 0);
        expect_now("reset_in_err1", 32'h0, 1'b1, 1'b0);
        drive(1, 0, 1, 0, 2'b10, 32'h0, 32'h0, 1, 1, 0, 0);
        drive(1, 0, 0, 0, 2'b00, 32'hCAFE_F00D, 32'h0, 1, 1, 0, 0);
        expect_now("post_reset_s1", 32'hCAFE_F00D, 1'b1, 1'b0);

        // Random traffic against the model only.
        rst_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if (rst_cnt > 0) rst_cnt--;
            else if ($urandom_range(0, 59) == 0) rst_cnt = $urandom_range(1, 3);
            pick = $urandom_range(0, 7);
            hd = (pick == 1) || (pick == 4);
            h1 = (pick == 2) || (pick == 5);
            h2 = (pick == 3) || (pick == 6);
            if (pick == 7) begin
                hd = 1'($urandom_range(0, 1));
                h1 = 1'($urandom_range(0, 1));
                h2 = 1'($urandom_range(0, 1));
            end
            drive(rst_cnt == 0, hd, h1, h2, 2'($urandom_range(0, 3)), $urandom, $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
        end

        drive(1, 0, 0, 0, 2'b00, 32'h0, 32'h0, 1, 1, 0, 0);
        @(negedge HCLK);
        #1;
        check("scoreboard_drained", 34'(exp_q.size()), 34'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_resp_mux.md
AHB_RESP_MUX -- requirements
Module: ahb_resp_mux

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, named HCLK and HRESETn as in the rest of the bus fabric.
REQ-002 HCLK  input  1  bus clock; all state updates on the rising edge.
REQ-003 HRESETn  input  1  asynchronous active-low reset.
REQ-004 HSEL_Default, HSEL_S1, HSEL_S2  input  1 each  address-phase selects from the address decoder.
REQ-005 HTRANS  input  2  master transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-006 HRDATA_S1, HRDATA_S2  input  32 each  slave read data.
REQ-007 HREADYOUT_S1, HREADYOUT_S2  input  1 each  slave ready.
REQ-008 HRESP_S1, HRESP_S2  input  1 each  slave response (0 OKAY, 1 ERROR).
REQ-009 HRDATA  output  32  muxed read data to the master.
REQ-010 HREADY  output  1  muxed ready, also broadcast to all slaves.
REQ-011 HRESP  output  1  muxed response to the master.

Function
REQ-012 The block SHALL hold a data-phase select register (DEF, S1, S2) loaded from the address-phase HSEL inputs on every rising HCLK edge where HREADY=1, and held when HREADY=0.
REQ-013 If more than one HSEL is high at load time, the priority SHALL be S1 > S2 > Default; if none is high, Default SHALL be loaded.
REQ-014 With select=S1 or S2, HRDATA/HREADY/HRESP SHALL equal that slave's HRDATA/HREADYOUT/HRESP combinationally (zero added latency).
REQ-015 With select=DEF, HRDATA SHALL be 32'h0000_0000, and HREADY/HRESP SHALL come from the internal default slave.
REQ-016 The default slave SHALL be an FSM with states DS_IDLE, DS_ERR1, DS_ERR2.
REQ-017 DS_IDLE: output HREADYOUT=1, HRESP=0; go to DS_ERR1 when HREADY=1, HSEL_Default=1 and HTRANS[1]=1; otherwise stay.
REQ-018 DS_ERR1: output HREADYOUT=0, HRESP=1; always go to DS_ERR2 next cycle.
REQ-019 DS_ERR2: output HREADYOUT=1, HRESP=1; go to DS_ERR1 if HSEL_Default=1 and HTRANS[1]=1 (back-to-back error), else DS_IDLE.
REQ-020 IDLE or BUSY transfers to the default slave SHALL receive a zero-wait OKAY response.
REQ-021 The default slave SHALL ignore HSEL_Default while HREADY=0.
REQ-022 A slave inserting wait states (HREADYOUT_Sx=0) SHALL stall the select register indefinitely; there is no timeout.
REQ-023 ERROR responses from S1/S2 SHALL pass through unmodified; the mux adds no state for them.

Reset
REQ-024 While HRESETn=0: select register = DEF, FSM = DS_IDLE, so HREADY=1, HRESP=0, HRDATA=32'h0.
REQ-025 Reset assertion mid-transfer (including DS_ERR1) SHALL abort immediately to the reset state; the first address phase after deassertion SHALL be sampled normally.

Structure
REQ-026 A shared package ahb_pkg SHALL hold the HTRANS encodings, HRESP codes (OKAY/ERROR), the select enumeration (SEL_DEF, SEL_S1, SEL_S2) and the default-slave state enumeration.
REQ-027 The default slave SHALL be a sub-module, ahb_default_slave (ports HCLK, HRESETn, HSEL, HTRANS, HREADY, HREADYOUT, HRESP), instantiated once.
REQ-028 Output muxing SHALL be combinational; only the select register and FSM state are flopped.

Verification
REQ-029 Reset: hold HRESETn=0 for 3 cycles -> HREADY=1, HRESP=0, HRDATA=32'h0 throughout.
REQ-030 S1 read: addr phase HSEL_S1=1, HTRANS=10; next cycle HRDATA_S1=32'hDEAD_BEEF, HREADYOUT_S1=1 -> HRDATA=32'hDEAD_BEEF, HREADY=1, HRESP=0.
REQ-031 Wait states: S2 selected, HREADYOUT_S2=0 for 3 cycles while HSEL_S1=1 is presented -> HREADY=0 for 3 cycles, select stays S2, switches to S1 only after HREADYOUT_S2=1.
REQ-032 Unmapped NONSEQ: HSEL_Default=1, HTRANS=10 -> next cycle HREADY=0/HRESP=1, following cycle HREADY=1/HRESP=1, then HREADY=1/HRESP=0.
REQ-033 Back-to-back errors: NONSEQ to Default presented again during DS_ERR2 -> response sequence (0,1),(1,1),(0,1),(1,1) for (HREADY,HRESP).
REQ-034 IDLE to Default: HSEL_Default=1, HTRANS=00 -> HREADY=1, HRESP=0 next cycle; reset asserted during DS_ERR1 -> HREADY=1, HRESP=0 immediately.
